alu_cmd_sequencer: RTL

- Upstream feeder for the registered 3-bit ALU.
- Accepts packed command words over a valid/ready handshake and drives the ALU input pins. For shift and rotate it holds each command for the requested repeat count.
- Waits out the ALU pipeline, captures the 6-bit result, and returns it with an error flag over a valid/ready response handshake.

---
 rtl/alu_seq_pkg.sv | 60 ++++++
 rtl/alu_cmd_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: command layout,
// opcode values, FSM encoding and the command decode helpers.
package alu_seq_pkg;

  localparam int CMD_W     = 19;
  localparam int DRV_W     = 16;
  localparam int OP_LSB    = 6;
  localparam int OP_W      = 3;
  localparam int RED_A_BIT = 12;
  localparam int RED_B_BIT = 13;
  localparam int REP_LSB   = 16;
  localparam int REP_W     = 3;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  // Bit order matches cmd_data[15:0], so the low half of a command casts straight in.
  typedef struct packed {
    logic       bypass_b;
    logic       bypass_a;
    logic       red_op_b;
    logic       red_op_a;
    logic       direction;
    logic       serial_in;
    logic       cin;
    logic [2:0] opcode;
    logic [2:0] b;
    logic [2:0] a;
  } drv_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Same condition the ALU uses to toggle its led; bypass does not mask it.
  function automatic logic calc_err(input logic [2:0] opcode,
                                    input logic       red_a,
                                    input logic       red_b);
    logic bad_op;
    logic bad_red;
    bad_op  = (opcode == 3'b110) || (opcode == 3'b111);
    bad_red = (opcode != OP_AND) && (opcode != OP_XOR) && (red_a || red_b);
    return bad_op || bad_red;
  endfunction

  function automatic logic [REP_W-1:0] calc_eff_rep(input logic [2:0]       opcode,
                                                    input logic [REP_W-1:0] rep);
    if (((opcode == OP_SHIFT) || (opcode == OP_ROTATE)) && (rep != '0))
      return rep;
    return REP_W'(1);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Feeds one command at a time into the registered ALU, repeating shift/rotate
// commands, then waits out the ALU pipeline and returns the captured result.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [5:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [2:0]        alu_A,
  output logic [2:0]        alu_B,
  output logic [2:0]        alu_opcode,
  output logic              alu_cin,
  output logic              alu_serial_in,
  output logic              alu_direction,
  output logic              alu_red_op_A,
  output logic              alu_red_op_B,
  output logic              alu_bypass_A,
  output logic              alu_bypass_B,
  input  logic [5:0]        alu_out
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(ALU_LATENCY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  drv_t             drv;
  logic             err_q;

  logic [OP_W-1:0]  in_opcode;
  logic [REP_W-1:0] in_rep;
  logic             in_err;
  logic [REP_W-1:0] in_eff_rep;

  assign in_opcode  = cmd_data[OP_LSB +: OP_W];
  assign in_rep     = cmd_data[REP_LSB +: REP_W];
  assign in_err     = calc_err(in_opcode, cmd_data[RED_A_BIT], cmd_data[RED_B_BIT]);
  assign in_eff_rep = calc_eff_rep(in_opcode, in_rep);

  // Both are pure decodes of the state register, so neither handshake input
  // can reach them combinationally.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign alu_A         = drv.a;
  assign alu_B         = drv.b;
  assign alu_opcode    = drv.opcode;
  assign alu_cin       = drv.cin;
  assign alu_serial_in = drv.serial_in;
  assign alu_direction = drv.direction;
  assign alu_red_op_A  = drv.red_op_a;
  assign alu_red_op_B  = drv.red_op_b;
  assign alu_bypass_A  = drv.bypass_a;
  assign alu_bypass_B  = drv.bypass_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drv       <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            drv   <= drv_t'(cmd_data[DRV_W-1:0]);
            err_q <= in_err;
            cnt   <= CNT_W'(in_eff_rep);
            state <= S_DRIVE;
          end
        end
        // Command stays on the pins for exactly eff_rep ALU input edges.
        S_DRIVE: begin
          if (cnt == CNT_ONE) begin
            drv   <= '0;
            cnt   <= SETTLE_CNT;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        // Zero drives flush the ALU so the next command starts from a clean out.
        S_SETTLE: begin
          if (cnt == CNT_ONE) begin
            rsp_data  <= alu_out;
            rsp_err   <= err_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
